// File: rtl/sha256_job_sched.sv
// -----------------------------------------------------------------------------
// sha256_job_sched
//
// Sequences a single sha256 engine across a queue of hash requests. Incoming
// descriptors land in a small FIFO; the scheduler pops one at a time, holds
// the engine in reset while it latches the parameters, pulses start, waits
// for the rising edge of done and then presents a completion to the
// requester before going back for the next descriptor.
//
// Optional feature macro: SHA_SCHED_TIMEOUT_EN
//   When defined, a watchdog aborts a job that stays in RUN for TIMEOUT
//   cycles and reports it with cmpl_status = 1. When undefined, no watchdog
//   exists, RUN waits indefinitely and cmpl_status is tied to 0.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   job_valid/job_ready   descriptor push handshake (ready = FIFO not full)
//   job_msg_addr/size/out_addr/tag   descriptor fields
//   eng_reset_n/eng_start engine control (engine is in reset unless running)
//   eng_message_addr/eng_size/eng_output_addr   engine job parameters
//   eng_done              engine done level
//   cmpl_valid/cmpl_ready completion handshake
//   cmpl_tag/cmpl_status  completed job tag and status (1 = timeout abort)
//   busy                  scheduler active or descriptors queued
//   jobs_done             wrapping count of completions handed off
// -----------------------------------------------------------------------------
module sha256_job_sched #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_msg_addr,
    input  logic [31:0] job_size,
    input  logic [31:0] job_out_addr,
    input  logic [3:0]  job_tag,
    output logic        eng_reset_n,
    output logic        eng_start,
    output logic [31:0] eng_message_addr,
    output logic [31:0] eng_size,
    output logic [31:0] eng_output_addr,
    input  logic        eng_done,
    output logic        cmpl_valid,
    input  logic        cmpl_ready,
    output logic [3:0]  cmpl_tag,
    output logic        cmpl_status,
    output logic        busy,
    output logic [15:0] jobs_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, RUN, REPORT} state_t;

    logic [99:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [31:0]   msg_q, msg_d;
    logic [31:0]   size_q, size_d;
    logic [31:0]   out_q, out_d;
    logic [3:0]    tag_q, tag_d;
    logic          done_q, done_d;
    logic [15:0]   jobs_q, jobs_d;
    logic          fifo_full, fifo_empty, push, pop;
    logic [99:0]   head;

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT - 1);
    logic [31:0]   wdog_q, wdog_d;
    logic          status_q, status_d;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign job_ready  = !fifo_full;
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign push       = job_valid && !fifo_full;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q];

    // Descriptor storage; no reset needed since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {job_tag, job_out_addr, job_size, job_msg_addr};
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop cancel.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Next-state logic. done_q follows eng_done everywhere except IDLE so a
    // done level already high when RUN is entered is not taken as completion.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        size_d  = size_q;
        out_d   = out_q;
        tag_d   = tag_q;
        done_d  = eng_done;
        jobs_d  = jobs_q;
`ifdef SHA_SCHED_TIMEOUT_EN
        wdog_d   = wdog_q;
        status_d = status_q;
`endif
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (!fifo_empty) begin
                    msg_d   = head[31:0];
                    size_d  = head[63:32];
                    out_d   = head[95:64];
                    tag_d   = head[99:96];
                    state_d = ARM;
`ifdef SHA_SCHED_TIMEOUT_EN
                    status_d = 1'b0;
`endif
                end
            end
            ARM: begin
                state_d = LAUNCH;
            end
            LAUNCH: begin
                state_d = RUN;
`ifdef SHA_SCHED_TIMEOUT_EN
                wdog_d = '0;
`endif
            end
            RUN: begin
                // Completion wins over a simultaneous watchdog expiry.
                if (eng_done && !done_q) begin
                    state_d = REPORT;
`ifdef SHA_SCHED_TIMEOUT_EN
                    status_d = 1'b0;
`endif
                end
`ifdef SHA_SCHED_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    state_d  = REPORT;
                    status_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`endif
            end
            REPORT: begin
                if (cmpl_ready) begin
                    jobs_d  = jobs_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops queued and in-flight work at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            msg_q    <= '0;
            size_q   <= '0;
            out_q    <= '0;
            tag_q    <= '0;
            done_q   <= 1'b0;
            jobs_q   <= '0;
`ifdef SHA_SCHED_TIMEOUT_EN
            wdog_q   <= '0;
            status_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            msg_q    <= msg_d;
            size_q   <= size_d;
            out_q    <= out_d;
            tag_q    <= tag_d;
            done_q   <= done_d;
            jobs_q   <= jobs_d;
`ifdef SHA_SCHED_TIMEOUT_EN
            wdog_q   <= wdog_d;
            status_q <= status_d;
`endif
        end
    end

    // The engine leaves reset only in LAUNCH and RUN; decoding from the state
    // register makes the asynchronous reset force it low immediately.
    assign eng_reset_n      = (state_q == LAUNCH) || (state_q == RUN);
    assign eng_start        = (state_q == LAUNCH);
    assign eng_message_addr = msg_q;
    assign eng_size         = size_q;
    assign eng_output_addr  = out_q;
    assign cmpl_valid       = (state_q == REPORT);
    assign cmpl_tag         = tag_q;
    assign busy             = (state_q != IDLE) || !fifo_empty;
    assign jobs_done        = jobs_q;
`ifdef SHA_SCHED_TIMEOUT_EN
    assign cmpl_status      = status_q;
`else
    assign cmpl_status      = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_job_sched.sv
// -----------------------------------------------------------------------------
// tb_sha256_job_sched
//
// Directed sequence with randomized descriptor contents and engine / completion
// delays. A queue of accepted descriptors models the scheduler: descriptors
// come out in push order, each launch must carry the head's parameters and
// each completion the head's tag. Launch latency, stale done, backpressure,
// FIFO full, reset mid-job and (with SHA_SCHED_TIMEOUT_EN) the watchdog are
// exercised.
// -----------------------------------------------------------------------------
module tb_sha256_job_sched;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 50;

    typedef struct {
        logic [31:0] msg;
        logic [31:0] size;
        logic [31:0] outAddr;
        logic [3:0]  tag;
    } job_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_msg_addr = '0;
    logic [31:0] job_size = '0;
    logic [31:0] job_out_addr = '0;
    logic [3:0]  job_tag = '0;
    logic        eng_reset_n;
    logic        eng_start;
    logic [31:0] eng_message_addr;
    logic [31:0] eng_size;
    logic [31:0] eng_output_addr;
    logic        eng_done = 1'b0;
    logic        cmpl_valid;
    logic        cmpl_ready = 1'b0;
    logic [3:0]  cmpl_tag;
    logic        cmpl_status;
    logic        busy;
    logic [15:0] jobs_done;

    job_t expQ[$];
    int   inflight = 0;
    int   jobsDone = 0;
    int   checkCount = 0;
    int   passCount = 0;
    int   failCount = 0;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    sha256_job_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .job_valid        (job_valid),
        .job_ready        (job_ready),
        .job_msg_addr     (job_msg_addr),
        .job_size         (job_size),
        .job_out_addr     (job_out_addr),
        .job_tag          (job_tag),
        .eng_reset_n      (eng_reset_n),
        .eng_start        (eng_start),
        .eng_message_addr (eng_message_addr),
        .eng_size         (eng_size),
        .eng_output_addr  (eng_output_addr),
        .eng_done         (eng_done),
        .cmpl_valid       (cmpl_valid),
        .cmpl_ready       (cmpl_ready),
        .cmpl_tag         (cmpl_tag),
        .cmpl_status      (cmpl_status),
        .busy             (busy),
        .jobs_done        (jobs_done)
    );

    // Advance one clock and settle just past the edge before touching anything.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic job_t makeJob(input logic [3:0] tag);
        job_t j;
        j.msg     = $urandom;
        j.size    = $urandom_range(1, 4096);
        j.outAddr = $urandom;
        j.tag     = tag;
        return j;
    endfunction

    // Offer one descriptor for one cycle; the model decides whether it fits.
    task automatic applyStimulus(input job_t j);
        bit expReady;
        expReady = (expQ.size() - inflight) < DEPTH;
        checkOutput("job_ready_before_push", job_ready, expReady);
        job_valid    = 1'b1;
        job_msg_addr = j.msg;
        job_size     = j.size;
        job_out_addr = j.outAddr;
        job_tag      = j.tag;
        tick();
        job_valid = 1'b0;
        if (expReady) expQ.push_back(j);
    endtask

    // Wait (bounded) for the start pulse and check it against the queue head.
    task automatic launchJob(input int expGap, input bit staleDone);
        int gap = 0;
        while (eng_start !== 1'b1 && gap < 40) begin
            tick();
            gap++;
        end
        checkOutput("launch_seen", eng_start, 1'b1);
        checkOutput("launch_gap", gap, expGap);
        checkOutput("launch_eng_reset_n", eng_reset_n, 1'b1);
        checkOutput("launch_msg_addr", eng_message_addr, expQ[0].msg);
        checkOutput("launch_size", eng_size, expQ[0].size);
        checkOutput("launch_out_addr", eng_output_addr, expQ[0].outAddr);
        inflight = 1;
        if (staleDone) eng_done = 1'b1;
        tick();
        checkOutput("start_one_cycle", eng_start, 1'b0);
        checkOutput("run_eng_reset_n", eng_reset_n, 1'b1);
    endtask

    // Drive the engine to completion (or let the watchdog fire) and hand off.
    task automatic finishJob(input int doneDelay, input int readyDelay, input bit staleDone, input bit expTimeout);
        if (expTimeout) begin
            repeat (TIMEOUT - 1) tick();
            checkOutput("no_report_before_timeout", cmpl_valid, 1'b0);
            tick();
        end else if (staleDone) begin
            repeat (8) tick();
            checkOutput("stale_done_ignored", cmpl_valid, 1'b0);
            eng_done = 1'b0;
            tick();
            checkOutput("done_low_no_report", cmpl_valid, 1'b0);
            eng_done = 1'b1;
            tick();
        end else begin
            repeat (doneDelay - 1) tick();
            checkOutput("no_report_while_running", cmpl_valid, 1'b0);
            eng_done = 1'b1;
            tick();
        end
        eng_done = 1'b0;
        checkOutput("cmpl_valid", cmpl_valid, 1'b1);
        checkOutput("cmpl_tag", cmpl_tag, expQ[0].tag);
        checkOutput("cmpl_status", cmpl_status, expTimeout);
        checkOutput("report_eng_reset_n", eng_reset_n, 1'b0);
        for (int i = 0; i < readyDelay; i++) begin
            tick();
            checkOutput("hold_cmpl_valid", cmpl_valid, 1'b1);
            checkOutput("hold_cmpl_tag", cmpl_tag, expQ[0].tag);
            checkOutput("hold_cmpl_status", cmpl_status, expTimeout);
            checkOutput("hold_eng_reset_n", eng_reset_n, 1'b0);
        end
        cmpl_ready = 1'b1;
        tick();
        cmpl_ready = 1'b0;
        jobsDone = (jobsDone + 1) % 65536;
        void'(expQ.pop_front());
        inflight = 0;
        checkOutput("jobs_done", jobs_done, jobsDone);
        checkOutput("cmpl_valid_drop", cmpl_valid, 1'b0);
    endtask

    initial begin
        job_t j;
        int   n;
        bit   sawValid, sawStart;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_job_ready", job_ready, 1'b1);
        checkOutput("rst_eng_reset_n", eng_reset_n, 1'b0);
        checkOutput("rst_eng_start", eng_start, 1'b0);
        checkOutput("rst_cmpl_valid", cmpl_valid, 1'b0);
        checkOutput("rst_cmpl_status", cmpl_status, 1'b0);
        checkOutput("rst_cmpl_tag", cmpl_tag, 4'd0);
        checkOutput("rst_msg_addr", eng_message_addr, 32'd0);
        checkOutput("rst_size", eng_size, 32'd0);
        checkOutput("rst_out_addr", eng_output_addr, 32'd0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_jobs_done", jobs_done, 16'd0);
        reset_n = 1'b1;
        tick();

        // Single job with a 300-cycle engine.
        $display("[TB] single job");
        j.msg = 32'h0; j.size = 32'd20; j.outAddr = 32'h100; j.tag = 4'd3;
        applyStimulus(j);
        checkOutput("busy_after_push", busy, 1'b1);
        tick();
        checkOutput("arm_eng_reset_n", eng_reset_n, 1'b0);
        checkOutput("arm_eng_start", eng_start, 1'b0);
        checkOutput("arm_size", eng_size, 32'd20);
        checkOutput("arm_out_addr", eng_output_addr, 32'h100);
        launchJob(1, 1'b0);
        finishJob(300, 0, 1'b0, 1'b0);
        tick();
        checkOutput("idle_busy", busy, 1'b0);

        // FIFO full: one job in the engine plus DEPTH queued.
        $display("[TB] fifo full");
        applyStimulus(makeJob(4'd0));
        launchJob(2, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(makeJob(4'(i)));
        checkOutput("full_job_ready", job_ready, 1'b0);
        applyStimulus(makeJob(4'd5));
        repeat (3) tick();
        checkOutput("full_job_ready_held", job_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            finishJob($urandom_range(2, 30), $urandom_range(0, 3), 1'b0, 1'b0);
            if (i < 4) launchJob(2, 1'b0);
        end
        repeat (4) tick();
        checkOutput("refused_job_not_run", busy, 1'b0);

        // Done already high when RUN starts.
        $display("[TB] stale done");
        applyStimulus(makeJob(4'($urandom_range(0, 15))));
        launchJob(2, 1'b1);
        finishJob(0, 2, 1'b1, 1'b0);

        // Completion backpressure with a second job queued.
        $display("[TB] backpressure");
        applyStimulus(makeJob(4'd9));
        applyStimulus(makeJob(4'd10));
        launchJob(1, 1'b0);
        finishJob($urandom_range(2, 20), 10, 1'b0, 1'b0);
        launchJob(2, 1'b0);
        finishJob($urandom_range(2, 20), 0, 1'b0, 1'b0);

        // Randomized bursts.
        $display("[TB] random bursts");
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) applyStimulus(makeJob(4'($urandom_range(0, 15))));
            launchJob(3 - n, 1'b0);
            for (int k = 0; k < n; k++) begin
                finishJob($urandom_range(1, 25), $urandom_range(0, 4), 1'b0, 1'b0);
                if (k < n - 1) launchJob(2, 1'b0);
            end
        end

`ifdef SHA_SCHED_TIMEOUT_EN
        // Watchdog abort followed by a normal job.
        $display("[TB] timeout");
        applyStimulus(makeJob(4'd6));
        applyStimulus(makeJob(4'd7));
        launchJob(1, 1'b0);
        finishJob(0, 0, 1'b0, 1'b1);
        launchJob(2, 1'b0);
        finishJob($urandom_range(2, 20), 1, 1'b0, 1'b0);
`endif

        // Reset in the middle of RUN with a job still queued.
        $display("[TB] reset mid-run");
        applyStimulus(makeJob(4'd1));
        applyStimulus(makeJob(4'd2));
        launchJob(1, 1'b0);
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_eng_reset_n", eng_reset_n, 1'b0);
        checkOutput("mid_rst_job_ready", job_ready, 1'b1);
        checkOutput("mid_rst_jobs_done", jobs_done, 16'd0);
        checkOutput("mid_rst_busy", busy, 1'b0);
        expQ.delete();
        inflight = 0;
        jobsDone = 0;
        tick();
        reset_n = 1'b1;
        sawValid = 1'b0;
        sawStart = 1'b0;
        for (int i = 0; i < 30; i++) begin
            eng_done = (i % 5) == 2;
            tick();
            sawValid |= cmpl_valid;
            sawStart |= eng_start;
        end
        eng_done = 1'b0;
        checkOutput("no_cmpl_after_reset", sawValid, 1'b0);
        checkOutput("no_launch_after_reset", sawStart, 1'b0);

        // Recovery: a fresh job runs and the counter restarts from zero.
        applyStimulus(makeJob(4'd12));
        launchJob(2, 1'b0);
        finishJob($urandom_range(2, 20), 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sha256_job_sched.md
# sha256_job_sched

Job scheduler that sequences the single `sha256` hash engine across a queue of hash requests. Software or an upstream master pushes descriptors (message address, byte size, output address, tag) into an internal FIFO. The scheduler re-arms the engine, launches each job, waits for completion and reports it through a completion handshake. It sits directly in front of `sha256` and owns that engine's `reset_n`, `start`, `message_addr`, `size` and `output_addr` inputs.

## Interface

Parameters:
- `DEPTH`, default 4: descriptor FIFO entries; power of two, at least 2.
- `TIMEOUT`, default 1000000: watchdog limit in RUN cycles; used only when `SHA_SCHED_TIMEOUT_EN` is defined.

Ports (clock and reset first):
- `clk`  in  1  single clock for the block and the engine.
- `reset_n`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  descriptor valid.
- `job_ready`  out  1  FIFO not full; equals `!full`, driven from registered occupancy.
- `job_msg_addr`  in  32  message word address.
- `job_size`  in  32  message size in bytes.
- `job_out_addr`  in  32  digest output word address.
- `job_tag`  in  4  requester tag, returned on completion.
- `eng_reset_n`  out  1  engine reset, active-low.
- `eng_start`  out  1  engine start pulse.
- `eng_message_addr`, `eng_size`, `eng_output_addr`  out  32 each  engine job parameters.
- `eng_done`  in  1  engine done.
- `cmpl_valid`  out  1  completion valid.
- `cmpl_ready`  in  1  completion accepted.
- `cmpl_tag`  out  4  tag of the completed job.
- `cmpl_status`  out  1  0 = digest written, 1 = timeout abort.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- `jobs_done`  out  16  count of completions handed off; wraps at 16 bits.

## Operation

- **FIFO.**
  - Storage: `DEPTH` entries of 100 bits (`{tag, out_addr, size, msg_addr}`).
  - Read and write pointers are `$clog2(DEPTH)` bits and wrap naturally.
  - The count is `$clog2(DEPTH)+1` bits.
  - A push occurs on `job_valid && job_ready`.
  - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states: IDLE, ARM, LAUNCH, RUN, REPORT.**
  - **IDLE.**
    - `eng_reset_n` = 0.
    - If the FIFO is non-empty: pop the head, register it into the `eng_*` parameter registers and the tag register, then go to ARM.
    - A push into an empty FIFO is not visible to IDLE in the same cycle.
  - **ARM.** Exactly one cycle. `eng_reset_n` = 0 with valid parameters, so the engine latches `message_addr` while in reset. Go to LAUNCH.
  - **LAUNCH.** Exactly one cycle. `eng_reset_n` = 1, `eng_start` = 1. Go to RUN.
  - **RUN.**
    - `eng_reset_n` = 1, `eng_start` = 0.
    - `done_q` registers `eng_done`. Completion is the rising edge `eng_done && !done_q`; a level that is already high is ignored.
    - On completion: `cmpl_status` = 0, go to REPORT.
  - **REPORT.**
    - `eng_reset_n` = 0.
    - `cmpl_valid` = 1 with `cmpl_tag` and `cmpl_status` held stable until `cmpl_ready`.
    - On handshake: `jobs_done` increments by 1 (modulo 2^16), then go to IDLE.
- `eng_message_addr`, `eng_size` and `eng_output_addr` stay constant from ARM through REPORT. They change only on a pop.
- `done_q` clears in IDLE.

## Timing

- Reset values:
  - state = IDLE.
  - `eng_reset_n` = 0 (asynchronously forced low).
  - `eng_start` = 0, `cmpl_valid` = 0, `cmpl_status` = 0, `cmpl_tag` = 0.
  - All `eng_*` address/size registers = 0.
  - FIFO empty, so `job_ready` = 1.
  - `busy` = 0, `jobs_done` = 0.
- Latency, empty FIFO and idle FSM:
  - Descriptor accepted at edge E0.
  - Pop at E1, FSM enters ARM.
  - LAUNCH at E2; `eng_start` is high for the single cycle E2–E3.
- `cmpl_valid` rises at the first edge after `eng_done` is first sampled high in RUN.
- Back-to-back jobs spend at least one cycle in IDLE between the REPORT handshake and the next ARM.
- `cmpl_ready` held high gives a one-cycle REPORT.
- Reset asserted mid-job:
  - All state clears immediately.
  - Queued and in-flight jobs are dropped.
  - No completion is reported.

## Configuration

- **`SHA_SCHED_TIMEOUT_EN` defined.**
  - A 32-bit watchdog counter clears on entry to RUN and increments every RUN cycle.
  - If the counter reaches `TIMEOUT`-1 without a completion edge: go to REPORT with `cmpl_status` = 1. The engine is held in reset there.
  - If a completion edge and the timeout occur in the same cycle, the completion wins (`cmpl_status` = 0).
- **`SHA_SCHED_TIMEOUT_EN` not defined.**
  - No watchdog logic is present.
  - RUN waits indefinitely and `cmpl_status` is constant 0.
  - `TIMEOUT` is ignored.

## Test plan

- **Single job.** Push `{msg 0x0000, size 20, out 0x0100, tag 3}`, engine model raises `eng_done` 300 cycles after start → `eng_start` is high exactly 2 cycles after acceptance; then `cmpl_valid` = 1, `cmpl_tag` = 3, `cmpl_status` = 0, `jobs_done` = 1.
- **FIFO full.** Push 5 jobs with `DEPTH` = 4 and the engine stalled → `job_ready` = 0 after the 5th push (4 queued plus 1 popped into the engine), and further pushes are refused. Completions return tags in push order 0..4.
- **Stale done.** Hold `eng_done` high from entry to RUN onward → no completion occurs until `eng_done` falls and rises again.
- **Completion backpressure.** `cmpl_ready` = 0 for 10 cycles → `cmpl_valid`, `cmpl_tag` and `cmpl_status` stay stable and `eng_reset_n` stays 0; the next job launches no earlier than 2 cycles after the handshake.
- **Reset mid-RUN.** Queue 2 jobs, drop `reset_n` while in RUN → `eng_reset_n` = 0 at once, `job_ready` = 1, `jobs_done` = 0, and no `cmpl_valid` afterwards.
- **Timeout (macro defined).** Set `TIMEOUT` = 50 and never raise `eng_done` → REPORT after 50 RUN cycles with `cmpl_status` = 1; the next queued job then launches normally.
